muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit with a restoring divider and shift-add multiplier.
// Optional macro MULDIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle 33x33 multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] negate32(input logic en, input logic [31:0] v);
        return en ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] negate64(input logic en, input logic [63:0] v);
        return en ? (64'd0 - v) : v;
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    function automatic logic [31:0] fast_mul(input logic [2:0] f, input logic sa, input logic sb,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        ea = {sa & a[31], a};
        eb = {sb & b[31], b};
        p  = 66'(ea) * 66'(eb);
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction
`endif

    state_t      state_r;
    logic [2:0]  op_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [4:0]  count_r;
    logic [31:0] acc_r;
    logic [31:0] shreg_r;
    logic [31:0] operand_r;

    logic        is_div_s;
    logic        a_signed_s;
    logic        b_signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        accept_s;
    logic        early_s;
    logic [31:0] early_result_s;

    logic [32:0] shifted_s;
    logic        ge_s;
    logic [31:0] sub_s;
    logic [32:0] sum_s;
    logic [31:0] acc_next_s;
    logic [31:0] sh_next_s;
    logic [63:0] product_s;
    logic [31:0] final_s;

    // Operand decode on the raw inputs; only consumed at an accepted start.
    assign is_div_s   = funct3[2];
    assign a_signed_s = funct3[2] ? ~funct3[0] : ((funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10));
    assign b_signed_s = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign a_neg_s    = a_signed_s & op_a[31];
    assign b_neg_s    = b_signed_s & op_b[31];
    assign a_mag_s    = negate32(a_neg_s, op_a);
    assign b_mag_s    = negate32(b_neg_s, op_b);
    assign div_zero_s = is_div_s & (op_b == 32'd0);
    assign div_ovf_s  = is_div_s & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    assign accept_s   = start & ((state_r == IDLE) | (state_r == DONE));

    // Operations that finish on the cycle after acceptance and their results.
    always_comb begin
        early_s        = 1'b0;
        early_result_s = 32'd0;
        if (div_zero_s) begin
            early_s        = 1'b1;
            early_result_s = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            early_s        = 1'b1;
            early_result_s = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div_s) begin
            early_s        = 1'b1;
            early_result_s = fast_mul(funct3, a_signed_s, b_signed_s, op_a, op_b);
        end
`endif
        else begin
            early_s        = 1'b0;
            early_result_s = 32'd0;
        end
    end

    // One iteration step: restoring-divide bit or shift-add multiply bit.
    always_comb begin
        shifted_s = {acc_r, shreg_r[31]};
        ge_s      = (shifted_s >= {1'b0, operand_r});
        sub_s     = shifted_s[31:0] - operand_r;
        sum_s     = {1'b0, acc_r} + (shreg_r[0] ? {1'b0, operand_r} : 33'd0);
        if (op_r[2]) begin
            acc_next_s = ge_s ? sub_s : shifted_s[31:0];
            sh_next_s  = {shreg_r[30:0], ge_s};
        end else begin
            acc_next_s = sum_s[32:1];
            sh_next_s  = {sum_s[0], shreg_r[31:1]};
        end
        product_s = negate64(neg_q_r, {acc_next_s, sh_next_s});
        if (op_r[2]) begin
            final_s = op_r[1] ? negate32(neg_r_r, acc_next_s) : negate32(neg_q_r, sh_next_s);
        end else begin
            final_s = (op_r[1:0] == 2'b00) ? product_s[31:0] : product_s[63:32];
        end
    end

    // Control FSM with registered busy/done/result and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            op_r      <= 3'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            count_r   <= 5'd0;
            acc_r     <= 32'd0;
            shreg_r   <= 32'd0;
            operand_r <= 32'd0;
        end else if (accept_s) begin
            op_r      <= funct3;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
            count_r   <= 5'd0;
            acc_r     <= 32'd0;
            shreg_r   <= is_div_s ? a_mag_s : b_mag_s;
            operand_r <= is_div_s ? b_mag_s : a_mag_s;
            if (early_s) begin
                state_r <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                result  <= early_result_s;
            end else begin
                state_r <= BUSY;
                busy    <= 1'b1;
                done    <= 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                BUSY: begin
                    acc_r   <= acc_next_s;
                    shreg_r <= sh_next_s;
                    if (count_r == 5'd31) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= final_s;
                    end else begin
                        count_r <= count_r + 5'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
